// File: rtl/instr_encoder_if.sv
// Request-side handshake bundle for instr_encoder: one symbolic operation per valid/ready transfer.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opsel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;

    modport master (output in_valid, opsel, rs, rt, rd, imm, input in_ready);
    modport slave  (input in_valid, opsel, rs, rt, rd, imm, output in_ready);
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: packs requests into 32-bit words, expands LI into LUI/ORI,
// and writes them sequentially into instruction memory. Define ENC_MULTU_EN to enable MULTU (opsel 5).
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    instr_encoder_if.slave       req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 err
);
    typedef enum logic [3:0] {
        OP_ADDU  = 4'd0,  OP_SUBU  = 4'd1,  OP_AND   = 4'd2,  OP_OR   = 4'd3,
        OP_SLTU  = 4'd4,  OP_MULTU = 4'd5,  OP_LW    = 4'd6,  OP_SW   = 4'd7,
        OP_BEQ   = 4'd8,  OP_ADDIU = 4'd9,  OP_J     = 4'd10, OP_LUI  = 4'd11,
        OP_ORI   = 4'd12, OP_BLTZ  = 4'd13, OP_LI    = 4'd14, OP_BAD  = 4'd15
    } op_e;

    typedef enum logic {S_IDLE, S_LO} state_e;

    localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    state_e        state_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [AW:0]   count_q;
    logic          err_q;
    logic [4:0]    li_rt_q;
    logic [15:0]   li_lo_q;

    op_e         op;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic        enc_li;
    logic        accept;
    logic        one_free;

    assign op       = op_e'(req.opsel);
    assign full     = (count_q == CAPACITY);
    assign one_free = (count_q == CAPACITY - ONE);
    assign req.in_ready = (state_q == S_IDLE) && !full && !flush;
    assign accept   = req.in_valid && req.in_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        enc_li   = 1'b0;
        case (op)
            OP_ADDU:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100001};
            OP_SUBU:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100011};
            OP_AND:   enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100100};
            OP_OR:    enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100101};
            OP_SLTU:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b101011};
`ifdef ENC_MULTU_EN
            OP_MULTU: enc_word = {6'b000000, req.rs, req.rt, 5'b0, 5'b0, 6'b011001};
`else
            OP_MULTU: enc_bad  = 1'b1;
`endif
            OP_LW:    enc_word = {6'b100011, req.rs, req.rt, req.imm[15:0]};
            OP_SW:    enc_word = {6'b101011, req.rs, req.rt, req.imm[15:0]};
            OP_BEQ:   enc_word = {6'b000100, req.rs, req.rt, req.imm[15:0]};
            OP_ADDIU: enc_word = {6'b001001, req.rs, req.rt, req.imm[15:0]};
            OP_J:     enc_word = {6'b000010, req.imm[25:0]};
            OP_LUI:   enc_word = {6'b001111, 5'b0, req.rt, req.imm[15:0]};
            OP_ORI:   enc_word = {6'b001101, req.rs, req.rt, req.imm[15:0]};
            OP_BLTZ:  enc_word = {6'b000001, req.rs, 5'b0, req.imm[15:0]};
            OP_LI: begin
                // First half of LI is the LUI of the upper immediate; ORI follows from S_LO.
                enc_li   = 1'b1;
                enc_word = {6'b001111, 5'b0, req.rt, req.imm[31:16]};
            end
            default:  enc_bad  = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            li_rt_q     <= '0;
            li_lo_q     <= '0;
        end else if (flush) begin
            state_q  <= S_IDLE;
            mem_we_q <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (enc_bad || (enc_li && one_free)) begin
                            err_q <= 1'b1;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= count_q[AW-1:0];
                            mem_wdata_q <= enc_word;
                            count_q     <= count_q + ONE;
                            if (enc_li) begin
                                state_q <= S_LO;
                                li_rt_q <= req.rt;
                                li_lo_q <= req.imm[15:0];
                            end
                        end
                    end
                end
                S_LO: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= count_q[AW-1:0];
                    mem_wdata_q <= {6'b001101, li_rt_q, li_rt_q, li_lo_q};
                    count_q     <= count_q + ONE;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder for the single-cycle MIPS core: the writer side of the instruction-decode path. Accepts symbolic operation requests over a valid/ready handshake and packs them into 32-bit MIPS words in the exact format the core's decoder consumes. It expands the `LI` pseudo-op into an LUI/ORI pair, then writes the words sequentially into instruction memory. Test programs and a boot loader use it to fill program memory without a host-side assembler.

## Interface
Parameters:
- `AW`, 8, instruction-memory word-address width; capacity 2**AW words

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of pointer, error and pending state
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge
- `opsel`  in  4  operation: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU, 5 MULTU, 6 LW, 7 SW, 8 BEQ, 9 ADDIU, 10 J, 11 LUI, 12 ORI, 13 BLTZ, 14 LI, 15 invalid
- `rs`, `rt`, `rd`  in  5 each  register fields
- `imm`  in  32  immediate; `[15:0]` for I-type, `[25:0]` for J, all 32 bits for LI
- `mem_we`  out  1  instruction-memory write strobe (one cycle per word)
- `mem_addr`  out  AW  word address of the current write
- `mem_wdata`  out  32  encoded instruction
- `count`  out  AW+1  words written since reset/flush
- `full`  out  1  `count == 2**AW`
- `err`  out  1  sticky error flag

## Operation
- Encodings:
  - R-type `{6'b000000, rs, rt, rd, 5'b0, funct}`. Funct values: ADDU 100001, SUBU 100011, AND 100100, OR 100101, SLTU 101011, MULTU 011001. MULTU forces rd = 0.
  - I-type `{op, rs, rt, imm[15:0]}`. Op values: LW 100011, SW 101011, BEQ 000100, ADDIU 001001, ORI 001101.
  - LUI `{001111, 5'b0, rt, imm[15:0]}`.
  - BLTZ `{000001, rs, 5'b0, imm[15:0]}`.
  - J `{000010, imm[25:0]}`.
- LI expands to two words:
  - first `LUI rt, imm[31:16]`;
  - second `ORI rt, rt, imm[15:0]`.
- FSM states:
  - IDLE: `in_ready = !full && !flush`. An accepted non-LI op emits one word and stays in IDLE. An accepted LI emits the LUI word and moves to LO.
  - LO: `in_ready = 0`. Emits the ORI word, then returns to IDLE.
- Write pointer: `mem_addr = count[AW-1:0]` at each write; `count` increments on every `mem_we` cycle.
- Error cases; each sets `err` and writes nothing:
  - opsel 15 accepted: no write, `count` unchanged.
  - LI accepted with exactly one free slot: no write, stays in IDLE.
- Requests presented while `full` are not accepted. `in_ready = 0`, so the upstream holds; `err` is not set.
- `flush` has highest priority. It forces IDLE, `count = 0`, `err = 0` and `mem_we = 0` in the following cycle, and drops any pending ORI word.
- Reset values: state IDLE, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`, `count = 0`, `full = 0`, `err = 0`. `in_ready` is 1 after reset deasserts.
- Reset asserted mid-LI: the pending ORI word is lost and all outputs return to their reset values immediately.

## Timing
- Accept at edge N: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid during cycle N+1. Latency is 1 cycle.
- LI accepted at edge N: LUI word in cycle N+1, ORI word in cycle N+2. `in_ready` is low during cycle N+1.
- Back-to-back non-LI requests sustain one word per cycle.
- `full` and `count` update at the same edge that drives the corresponding `mem_we` cycle. `in_ready` drops in the cycle in which the last slot is being written.
- `err` rises in the cycle after the offending accept and remains high until `flush` or `reset`.

## Configuration
- `ENC_MULTU_EN` defined: opsel 5 encodes MULTU (funct 011001).
- `ENC_MULTU_EN` undefined: opsel 5 is treated exactly like opsel 15, i.e. accepted, no write, `err` set.

## Test plan
- ADDU rs=1, rt=2, rd=3 after reset -> next cycle `mem_we = 1`, `mem_addr = 0`, `mem_wdata = 0x00221821`; then `count = 1`.
- LI rt=8, imm=0x12345678 -> cycle 1 `0x3C081234` at addr 0, cycle 2 `0x35085678` at addr 1; `in_ready` low for one cycle; `count = 2`.
- Back-to-back LW rs=29, rt=4, imm=0x0010 then J imm=0x40 -> `0x8FA40010` and `0x08000040` in consecutive cycles at addrs 0 and 1.
- With `ENC_MULTU_EN`: MULTU rs=5, rt=6 -> `0x00A60019`. Without the macro: no write and `err = 1`.
- AW=2: four ADDU writes -> `full = 1`, `count = 4`, `in_ready = 0`. Next, flush -> `count = 0`, `in_ready = 1`.
- AW=2: three writes, then LI -> `err = 1` and `count` stays at 3. Also, assert `reset` in the cycle between the LUI and ORI words -> no ORI write and all outputs at their reset values.
